// File: rtl/mac_result_drain.sv
// Result drain for the bit-serial matrix MAC: captures a finished accumulator tile,
// then requantizes and streams its elements out row-major, one per handshake beat.
module mac_result_drain #(
    parameter  int M         = 2,
    parameter  int N         = 2,
    parameter  int OUT_WIDTH = 8,
    localparam int RowW      = (M > 1) ? $clog2(M) : 1,
    localparam int ColW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [M-1:0][N-1:0][31:0]        data_i,
    input  logic [4:0]                       shift_i,
    input  logic                             round_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic signed [OUT_WIDTH-1:0]      data_o,
    output logic [RowW-1:0]                  row_o,
    output logic [ColW-1:0]                  col_o,
    output logic                             last_o,
    output logic                             busy_o
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    localparam logic signed [33:0] MaxVal = (34'sd1 <<< (OUT_WIDTH - 1)) - 34'sd1;
    localparam logic signed [33:0] MinVal = -(34'sd1 <<< (OUT_WIDTH - 1));

    logic [0:0]                 state;
    logic [M-1:0][N-1:0][31:0]  tileBuf;
    logic [4:0]                 shiftQ;
    logic                       roundQ;
    logic [RowW-1:0]            rowCnt;
    logic [ColW-1:0]            colCnt;

    logic                       atLast;
    logic                       beat;
    logic                       accept;
    logic signed [31:0]         elem;
    logic signed [33:0]         extElem;
    logic signed [33:0]         roundAdd;
    logic signed [33:0]         sum;
    logic signed [33:0]         shifted;
    logic signed [OUT_WIDTH-1:0] satVal;

    assign atLast  = (state == STREAM) && (rowCnt == RowW'(M - 1)) && (colCnt == ColW'(N - 1));
    assign valid_o = (state == STREAM);
    assign beat    = valid_o & ready_i;
    // A new tile may only land on the edge that retires the final element.
    assign ready_o = (state == IDLE) | (atLast & ready_i);
    assign accept  = valid_i & ready_o;

    assign busy_o  = valid_o;
    assign last_o  = atLast;
    assign row_o   = rowCnt;
    assign col_o   = colCnt;
    assign elem    = tileBuf[rowCnt][colCnt];

    // 34-bit datapath keeps the rounding add free of overflow before saturation.
    always_comb begin
        extElem  = {{2{elem[31]}}, elem};
        roundAdd = '0;
        if (roundQ && (shiftQ != 5'd0)) begin
            roundAdd = 34'sd1 <<< (shiftQ - 5'd1);
        end
        sum     = extElem + roundAdd;
        shifted = sum >>> shiftQ;
        if (shifted > MaxVal) begin
            satVal = OUT_WIDTH'(MaxVal);
        end else if (shifted < MinVal) begin
            satVal = OUT_WIDTH'(MinVal);
        end else begin
            satVal = OUT_WIDTH'(shifted);
        end
        data_o = (state == STREAM) ? satVal : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            tileBuf <= '0;
            shiftQ  <= '0;
            roundQ  <= 1'b0;
            rowCnt  <= '0;
            colCnt  <= '0;
        end else if (accept) begin
            state   <= STREAM;
            tileBuf <= data_i;
            shiftQ  <= shift_i;
            roundQ  <= round_i;
            rowCnt  <= '0;
            colCnt  <= '0;
        end else if (beat) begin
            if (atLast) begin
                state  <= IDLE;
                rowCnt <= '0;
                colCnt <= '0;
            end else if (colCnt == ColW'(N - 1)) begin
                colCnt <= '0;
                rowCnt <= rowCnt + RowW'(1);
            end else begin
                colCnt <= colCnt + ColW'(1);
            end
        end
    end

endmodule
